// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, two combinational read ports, optional
// write-to-read forwarding, optional hardwired-zero register 0 and a sequential clear
// sweep that zeroes one register per cycle.
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RESET          synchronous active-high reset, aborts any sweep
//   WE0/WE1        write enables (port 1 wins on an address collision)
//   WADDR0/WADDR1  write addresses
//   WDATA0/WDATA1  write data
//   RADDR1/RADDR2  read addresses
//   RDATA1/RDATA2  read data (combinational)
//   CLEAR          start a clear sweep (ignored while BUSY)
//   BUSY           high while the sweep is in progress
//   VALID          per-register "written since last reset/clear" flags
module reg_file_mp #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned ADDR_W   = 3,
  parameter int unsigned BYPASS   = 1,
  parameter int unsigned ZERO_REG = 0
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 WE0,
  input  logic                 WE1,
  input  logic [ADDR_W-1:0]    WADDR0,
  input  logic [ADDR_W-1:0]    WADDR1,
  input  logic [DATA_W-1:0]    WDATA0,
  input  logic [DATA_W-1:0]    WDATA1,
  input  logic [ADDR_W-1:0]    RADDR1,
  input  logic [ADDR_W-1:0]    RADDR2,
  output logic [DATA_W-1:0]    RDATA1,
  output logic [DATA_W-1:0]    RDATA2,
  input  logic                 CLEAR,
  output logic                 BUSY,
  output logic [2**ADDR_W-1:0] VALID
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic {StIdle, StSweep} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   regs_q [DEPTH];
  logic [DATA_W-1:0]   regs_d [DEPTH];
  logic [DEPTH-1:0]    valid_q, valid_d;

  logic busy;
  logic wr_en0, wr_en1;
  logic zero_en;

  assign busy    = (state_q == StSweep);
  assign zero_en = (ZERO_REG != 0);

  // Qualified write enables: no writes while sweeping, none to a hardwired register 0.
  assign wr_en0 = WE0 && !busy && !(zero_en && (WADDR0 == '0));
  assign wr_en1 = WE1 && !busy && !(zero_en && (WADDR1 == '0));

  // Next-state: sweep FSM, register contents and valid flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    valid_d = valid_q;

    if (RESET) begin
      state_d = StIdle;
      cnt_d   = '0;
      regs_d  = '{default: '0};
      valid_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Port 0 first so port 1 overwrites on a collision.
          if (wr_en0) begin
            regs_d[WADDR0]  = WDATA0;
            valid_d[WADDR0] = 1'b1;
          end
          if (wr_en1) begin
            regs_d[WADDR1]  = WDATA1;
            valid_d[WADDR1] = 1'b1;
          end
          if (CLEAR) begin
            state_d = StSweep;
            cnt_d   = '0;
          end
        end
        StSweep: begin
          regs_d[cnt_q]  = '0;
          valid_d[cnt_q] = 1'b0;
          if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + ADDR_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
    regs_q  <= regs_d;
    valid_q <= valid_d;
  end

  // Read port 1; port 1 write data takes precedence over port 0 when both forward.
  always_comb begin
    RDATA1 = regs_q[RADDR1];
    if (BYPASS != 0) begin
      if (wr_en1 && (WADDR1 == RADDR1)) begin
        RDATA1 = WDATA1;
      end else if (wr_en0 && (WADDR0 == RADDR1)) begin
        RDATA1 = WDATA0;
      end
    end
    if (zero_en && (RADDR1 == '0)) begin
      RDATA1 = '0;
    end
  end

  // Read port 2, same forwarding rules as port 1.
  always_comb begin
    RDATA2 = regs_q[RADDR2];
    if (BYPASS != 0) begin
      if (wr_en1 && (WADDR1 == RADDR2)) begin
        RDATA2 = WDATA1;
      end else if (wr_en0 && (WADDR0 == RADDR2)) begin
        RDATA2 = WDATA0;
      end
    end
    if (zero_en && (RADDR2 == '0)) begin
      RDATA2 = '0;
    end
  end

  assign BUSY  = busy;
  assign VALID = valid_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp. Three instances share the inputs: default parameters
// (forwarding on), forwarding off, and hardwired register 0.
module tb_reg_file_mp;

  logic       CLK;
  logic       RESET;
  logic       WE0, WE1;
  logic [2:0] WADDR0, WADDR1;
  logic [7:0] WDATA0, WDATA1;
  logic [2:0] RADDR1, RADDR2;
  logic       CLEAR;

  logic [7:0] rd1_a, rd2_a, rd1_n, rd2_n, rd1_z, rd2_z;
  logic       busy_a, busy_n, busy_z;
  logic [7:0] valid_a, valid_n, valid_z;

  int checks = 0;
  int errors = 0;

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(0)) dut_a (
    .CLK(CLK), .RESET(RESET), .WE0(WE0), .WE1(WE1), .WADDR0(WADDR0), .WADDR1(WADDR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1), .RADDR1(RADDR1), .RADDR2(RADDR2),
    .RDATA1(rd1_a), .RDATA2(rd2_a), .CLEAR(CLEAR), .BUSY(busy_a), .VALID(valid_a)
  );

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(0), .ZERO_REG(0)) dut_n (
    .CLK(CLK), .RESET(RESET), .WE0(WE0), .WE1(WE1), .WADDR0(WADDR0), .WADDR1(WADDR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1), .RADDR1(RADDR1), .RADDR2(RADDR2),
    .RDATA1(rd1_n), .RDATA2(rd2_n), .CLEAR(CLEAR), .BUSY(busy_n), .VALID(valid_n)
  );

  reg_file_mp #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut_z (
    .CLK(CLK), .RESET(RESET), .WE0(WE0), .WE1(WE1), .WADDR0(WADDR0), .WADDR1(WADDR1),
    .WDATA0(WDATA0), .WDATA1(WDATA1), .RADDR1(RADDR1), .RADDR2(RADDR2),
    .RDATA1(rd1_z), .RDATA2(rd2_z), .CLEAR(CLEAR), .BUSY(busy_z), .VALID(valid_z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance past one rising edge; inputs change and outputs are sampled away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    WE0 = 0; WE1 = 0; CLEAR = 0; RESET = 0;
  endtask

  initial begin
    RESET = 1; WE0 = 0; WE1 = 0; CLEAR = 0;
    WADDR0 = 0; WADDR1 = 0; WDATA0 = 0; WDATA1 = 0; RADDR1 = 0; RADDR2 = 0;
    tick();
    RESET = 0;
    RADDR1 = 3; RADDR2 = 6;
    #1;
    chk("rst_rdata1", rd1_a, 0);
    chk("rst_rdata2", rd2_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_valid", valid_a, 0);

    // Single write, read back next cycle.
    WE0 = 1; WADDR0 = 3; WDATA0 = 8'h5A;
    tick();
    idle_inputs(); RADDR1 = 3;
    #1;
    chk("wr_read", rd1_a, 8'h5A);
    chk("wr_valid", valid_a, 8'h08);
    chk("wr_read_nobyp", rd1_n, 8'h5A);

    // Same-address collision, port 1 wins, forwarded in the same cycle.
    WE0 = 1; WADDR0 = 2; WDATA0 = 8'h11;
    WE1 = 1; WADDR1 = 2; WDATA1 = 8'h22;
    RADDR2 = 2;
    #1;
    chk("coll_bypass", rd2_a, 8'h22);
    chk("coll_nobyp_old", rd2_n, 8'h00);
    tick();
    idle_inputs(); RADDR1 = 2;
    #1;
    chk("coll_stored", rd1_a, 8'h22);
    chk("coll_valid", valid_a, 8'h0C);

    // Forwarding from each port to a different read port.
    WE0 = 1; WADDR0 = 4; WDATA0 = 8'h44;
    WE1 = 1; WADDR1 = 5; WDATA1 = 8'h77;
    RADDR1 = 4; RADDR2 = 5;
    #1;
    chk("byp_port0", rd1_a, 8'h44);
    chk("byp_port1", rd2_a, 8'h77);
    chk("nobyp_port0", rd1_n, 8'h00);
    chk("nobyp_port1", rd2_n, 8'h00);
    tick();
    idle_inputs();
    #1;
    chk("nobyp_stored", rd2_n, 8'h77);
    chk("valid_3c", valid_a, 8'h3C);

    // Hardwired register 0.
    WE0 = 1; WADDR0 = 0; WDATA0 = 8'hFF; RADDR1 = 0;
    #1;
    chk("zr_no_bypass", rd1_z, 8'h00);
    chk("a_bypass_r0", rd1_a, 8'hFF);
    tick();
    idle_inputs();
    #1;
    chk("zr_read0", rd1_z, 8'h00);
    chk("zr_valid", valid_z, 8'h3C);
    chk("a_read0", rd1_a, 8'hFF);
    chk("a_valid", valid_a, 8'h3D);

    // Fill all registers.
    for (int i = 0; i < 8; i++) begin
      WE0 = 1; WADDR0 = 3'(i); WDATA0 = 8'(8'h10 + i);
      tick();
    end
    idle_inputs(); RADDR1 = 7;
    #1;
    chk("fill_r7", rd1_a, 8'h17);
    chk("fill_valid", valid_a, 8'hFF);
    chk("fill_valid_zr", valid_z, 8'hFE);

    // Write and CLEAR in the same idle cycle: the write lands, then gets swept.
    WE1 = 1; WADDR1 = 6; WDATA1 = 8'hAB; CLEAR = 1;
    #1;
    chk("pre_clear_busy", busy_a, 0);
    tick();
    idle_inputs(); RADDR1 = 6;
    #1;
    chk("clr_write_landed", rd1_a, 8'hAB);

    for (int k = 0; k < 8; k++) begin
      RADDR1 = 3'(k);
      RADDR2 = 3'((k == 0) ? 0 : k - 1);
      if (k == 2) begin
        // Write during the sweep must be ignored and not forwarded.
        WE0 = 1; WADDR0 = 7; WDATA0 = 8'hEE; RADDR1 = 7;
        CLEAR = 1;
      end
      #1;
      chk("sweep_busy", busy_a, 1);
      if (k == 2) chk("sweep_no_fwd", rd1_a, 8'h17);
      else chk("sweep_unswept", rd1_a, (k == 6) ? 8'hAB : 8'(8'h10 + k));
      if (k > 0) chk("sweep_swept", rd2_a, 8'h00);
      tick();
      idle_inputs();
    end
    RADDR1 = 7;
    #1;
    chk("sweep_done_busy", busy_a, 0);
    chk("sweep_done_valid", valid_a, 8'h00);
    chk("sweep_ignored_wr", rd1_a, 8'h00);
    // CLEAR during the sweep must not have restarted it.
    tick();
    chk("no_restart_busy", busy_a, 0);

    // Reset in the middle of a sweep.
    WE0 = 1; WADDR0 = 1; WDATA0 = 8'h31;
    WE1 = 1; WADDR1 = 7; WDATA1 = 8'h37;
    tick();
    idle_inputs(); CLEAR = 1;
    tick();
    idle_inputs();
    tick(); tick(); tick();
    RADDR1 = 7;
    #1;
    chk("mid_sweep_busy", busy_a, 1);
    chk("mid_sweep_r7", rd1_a, 8'h37);
    RESET = 1;
    tick();
    RESET = 0; RADDR1 = 7; RADDR2 = 1;
    #1;
    chk("abort_busy", busy_a, 0);
    chk("abort_r7", rd1_a, 8'h00);
    chk("abort_r1", rd2_a, 8'h00);
    chk("abort_valid", valid_a, 8'h00);
    WE0 = 1; WADDR0 = 7; WDATA0 = 8'h55;
    tick();
    idle_inputs();
    #1;
    chk("abort_idle_write", rd1_a, 8'h55);
    chk("abort_idle_valid", valid_a, 8'h80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
REG_FILE_MP -- requirements
Module: reg_file_mp

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 3, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter BYPASS, default 1, meaning 1 enables write-to-read forwarding.
REQ-004 The block SHALL have parameter ZERO_REG, default 0, meaning 1 hardwires register 0 to zero.
REQ-005 The block SHALL have port CLK, input, 1 bit, the clock; all state changes on its rising edge.
REQ-006 The block SHALL have port RESET, input, 1 bit, a synchronous, active-high reset.
REQ-007 The block SHALL have ports WE0/WE1, input, 1 bit each, write enables for write ports 0 and 1.
REQ-008 The block SHALL have ports WADDR0/WADDR1, input, ADDR_W bits each, write addresses.
REQ-009 The block SHALL have ports WDATA0/WDATA1, input, DATA_W bits each, write data.
REQ-010 The block SHALL have ports RADDR1/RADDR2, input, ADDR_W bits each, read addresses.
REQ-011 The block SHALL have ports RDATA1/RDATA2, output, DATA_W bits each, read data.
REQ-012 The block SHALL have port CLEAR, input, 1 bit, a request to start a sequential clear sweep.
REQ-013 The block SHALL have port BUSY, output, 1 bit, high while the sweep is in progress.
REQ-014 The block SHALL have port VALID, output, DEPTH bits, where bit i is high iff register i has been written since the last reset or clear.

Function
REQ-015 Reads SHALL be combinational with no modelled delay; RDATAn = regfile[RADDRn].
REQ-016 A write with WEn=1 and BUSY=0 SHALL update regfile[WADDRn] at the rising edge and set VALID[WADDRn] at the same edge.
REQ-017 If WE0=WE1=1 and WADDR0==WADDR1, port 1 data SHALL win.
REQ-018 With BYPASS=1, a read whose RADDR matches an active write address in the same cycle SHALL return that write data; if both ports match, port 1 SHALL be returned; with BYPASS=0 the read SHALL return the stored value.
REQ-019 With ZERO_REG=1, register 0 SHALL read 0, ignore writes, receive no bypass and keep VALID[0]=0.
REQ-020 The sweep FSM SHALL have states IDLE and SWEEP, with a counter cnt of width ADDR_W.
REQ-021 In IDLE with CLEAR=1, the FSM SHALL move to SWEEP with cnt=0 and BUSY=1 from the next cycle.
REQ-022 In SWEEP, each cycle SHALL zero regfile[cnt] and clear VALID[cnt], then increment cnt.
REQ-023 When cnt==DEPTH-1, that register SHALL be cleared and the FSM SHALL return to IDLE; the sweep takes exactly DEPTH cycles.
REQ-024 While BUSY=1, writes SHALL be ignored, bypass SHALL be disabled and CLEAR SHALL be ignored; reads SHALL return current contents, so partially swept values are visible.
REQ-025 A write and CLEAR asserted in the same IDLE cycle SHALL both take effect: the write lands, then the sweep later zeroes it.

Reset
REQ-026 RESET=1 at a rising edge SHALL zero all registers, clear VALID, force IDLE, set cnt=0 and BUSY=0 in that single cycle.
REQ-027 RESET SHALL take priority over writes, CLEAR and an in-progress sweep, aborting it.
REQ-028 After reset, RDATA1=RDATA2=0, BUSY=0 and VALID=0.

Verification
REQ-029 Reset, then WE0=1, WADDR0=3, WDATA0=0x5A; next cycle RADDR1=3 -> RDATA1=0x5A and VALID=0x08.
REQ-030 Same edge WE0: addr 2, 0x11 and WE1: addr 2, 0x22 -> register 2 = 0x22; bypass read of addr 2 in that cycle -> 0x22.
REQ-031 BYPASS=1, WE1 addr 5, 0x77 with RADDR2=5 in the same cycle -> RDATA2=0x77 before the edge; with BYPASS=0 -> old value.
REQ-032 Fill all 8 registers, pulse CLEAR -> BUSY high for exactly 8 cycles, registers zero in order 0..7, a write during BUSY is ignored, VALID=0 at the end.
REQ-033 RESET asserted at sweep cycle 3 -> next cycle all registers 0, BUSY=0 and the FSM in IDLE.
REQ-034 ZERO_REG=1, write 0xFF to addr 0 -> RDATA=0 and VALID[0]=0.
